// File: rtl/alu_pkg.sv
// Shared types and constants for the MIPS32 execute-stage ALU.
// The operation codes map one-to-one onto aluControl.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_RSVD = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for ADD, SUB and SLT: computes a + (b ^ {sub}) + sub.
// Overflow uses the post-inversion operand so one rule covers both directions.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = b_i ^ {WIDTH{sub_i}};
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH+1)'(sub_i);
  assign overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Combinational MIPS32 ALU with zero detect, plus a sticky signed-overflow
// status bit that is cleared only by the asynchronous reset.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       aluControl,
  output logic [WIDTH-1:0] aluResult,
  output logic             zeroFlag,
  output logic             overflow,
  output logic             carryOut,
  output logic             ovfSticky
);

  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic             add_carry;
  logic             add_ovf;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;
  logic             carry_d;
  logic             ovf_sticky_q;
  logic             ovf_sticky_d;

  assign op = alu_op_e'(aluControl);

  // aluControl[2] selects subtraction for SUB and SLT; other ops ignore the adder.
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i        (srcA),
    .b_i        (srcB),
    .sub_i      (aluControl[2]),
    .sum_o      (sum),
    .carry_o    (add_carry),
    .overflow_o (add_ovf)
  );

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    carry_d  = 1'b0;
    case (op)
      ALU_AND:  result_d = srcA & srcB;
      ALU_OR:   result_d = srcA | srcB;
      ALU_ANDN: result_d = srcA & ~srcB;
      ALU_ORN:  result_d = srcA | ~srcB;
      ALU_ADD, ALU_SUB: begin
        result_d = sum;
        ovf_d    = add_ovf;
        carry_d  = add_carry;
      end
      // Sign of the difference corrected by overflow gives a true signed compare.
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default:  result_d = '0;
    endcase
  end

  assign aluResult = result_d;
  assign zeroFlag  = (result_d == '0);
  assign overflow  = ovf_d;
  assign carryOut  = carry_d;

  assign ovf_sticky_d = ovf_sticky_q | ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovfSticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with fixed expected values,
// then randomized vectors checked against a plain-arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic [2:0]  aluControl = 3'b000;
  logic [31:0] aluResult;
  logic        zeroFlag;
  logic        overflow;
  logic        carryOut;
  logic        ovfSticky;

  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_ov_cur = 1'b0;
  logic exp_sticky;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srcA       (srcA),
    .srcB       (srcB),
    .aluControl (aluControl),
    .aluResult  (aluResult),
    .zeroFlag   (zeroFlag),
    .overflow   (overflow),
    .carryOut   (carryOut),
    .ovfSticky  (ovfSticky)
  );

  always #5 clk = ~clk;

  // Sticky model: any sampled overflowing input sets it, only reset clears it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          exp_sticky <= 1'b0;
    else if (exp_ov_cur) exp_sticky <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                           output logic [31:0] res, output logic ov, output logic co);
    longint sa, sb, ua, ub, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    res = '0;
    ov  = 1'b0;
    co  = 1'b0;
    case (ctl)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b100: res = a & ~b;
      3'b101: res = a | ~b;
      3'b010: begin
        s   = sa + sb;
        res = a + b;
        ov  = (s > S_MAX) || (s < S_MIN);
        co  = (ua + ub) > 64'sd4294967295;
      end
      3'b110: begin
        s   = sa - sb;
        res = a - b;
        ov  = (s > S_MAX) || (s < S_MIN);
        co  = (ua >= ub);
      end
      3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
      default: res = '0;
    endcase
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                       input string tag);
    logic [31:0] r;
    logic        ov, co;
    @(negedge clk);
    check({tag, ".sticky"}, {31'd0, ovfSticky}, {31'd0, exp_sticky});
    srcA = a;
    srcB = b;
    aluControl = ctl;
    #1;
    ref_model(a, b, ctl, r, ov, co);
    exp_ov_cur = ov;
    check({tag, ".res"}, aluResult, r);
    check({tag, ".zero"}, {31'd0, zeroFlag}, {31'd0, r == 32'd0});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ov});
    check({tag, ".cout"}, {31'd0, carryOut}, {31'd0, co});
  endtask

  task automatic apply_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                           input string tag, input logic [31:0] exp_res);
    apply(a, b, ctl, tag);
    check({tag, ".const"}, aluResult, exp_res);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset held low: combinational path works, sticky stays clear.
    apply_exp(32'd2, 32'd3, 3'b010, "rst_add", 32'd5);
    check("rst_add.sticky_low", {31'd0, ovfSticky}, 32'd0);
    rst_n = 1'b1;

    apply_exp(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, "and",  32'h00F000F0);
    apply_exp(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, "or",   32'hFFF0FFF0);
    apply_exp(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, "andn", 32'hF000F000);
    apply_exp(32'hF0F0F0F0, 32'h0FF00FF0, 3'b101, "orn",  32'hF0FFF0FF);
    apply_exp(32'd7, 32'd5, 3'b010, "add7_5", 32'd12);
    apply_exp(32'd5, 32'd5, 3'b110, "sub5_5", 32'd0);
    check("sub5_5.zero_const", {31'd0, zeroFlag}, 32'd1);
    apply_exp(32'd3, 32'd5, 3'b110, "sub3_5", 32'hFFFFFFFE);
    apply_exp(32'hFFFFFFFF, 32'd1, 3'b010, "add_wrap", 32'd0);
    check("add_wrap.cout_const", {31'd0, carryOut}, 32'd1);
    check("add_wrap.ovf_const", {31'd0, overflow}, 32'd0);
    apply_exp(32'hFFFFFFFF, 32'd1, 3'b111, "slt_m1_1", 32'd1);
    apply_exp(32'd1, 32'hFFFFFFFF, 3'b111, "slt_1_m1", 32'd0);
    apply_exp(32'd5, 32'd5, 3'b111, "slt_5_5", 32'd0);
    apply_exp(32'h80000000, 32'h7FFFFFFF, 3'b111, "slt_min_max", 32'd1);
    apply_exp(32'h7FFFFFFF, 32'h80000000, 3'b111, "slt_max_min", 32'd0);
    apply_exp(32'd9, 32'd4, 3'b011, "rsvd", 32'd0);
    check("rsvd.zero_const", {31'd0, zeroFlag}, 32'd1);
    check("rsvd.sticky_clear", {31'd0, ovfSticky}, 32'd0);

    // Overflow sets the sticky bit, which survives non-overflowing inputs.
    apply_exp(32'h7FFFFFFF, 32'd1, 3'b010, "add_ovf", 32'h80000000);
    check("add_ovf.ovf_const", {31'd0, overflow}, 32'd1);
    apply_exp(32'd3, 32'd4, 3'b010, "add3_4a", 32'd7);
    check("add3_4a.sticky_set", {31'd0, ovfSticky}, 32'd1);
    apply_exp(32'd3, 32'd4, 3'b010, "add3_4b", 32'd7);
    check("add3_4b.sticky_hold", {31'd0, ovfSticky}, 32'd1);

    // Asynchronous clear away from any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_clr.sticky", {31'd0, ovfSticky}, 32'd0);
    check("async_clr.res", aluResult, 32'd7);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      apply(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), $sformatf("rand%0d", i));
    end
    @(negedge clk);
    check("final.sticky", {31'd0, ovfSticky}, {31'd0, exp_sticky});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit combinational integer ALU for the MIPS32 execute stage. It computes a logic, arithmetic or set-less-than result of `srcA` and `srcB` under a 3-bit `aluControl` code, and raises `zeroFlag` when the result is zero. `EX` instantiates it and registers `aluResult`/`zeroFlag` itself, so the datapath outputs must be valid in the same cycle as the inputs. A small clocked status register keeps a sticky overflow indication for debug and exception logic.

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is required to work.
- `clk`  input  1: single clock; clocks the sticky status register only.
- `rst_n`  input  1: asynchronous, active-low reset.
- `srcA`  input  WIDTH: operand A (rs).
- `srcB`  input  WIDTH: operand B (rt or sign-extended immediate, selected upstream).
- `aluControl`  input  3: operation select.
- `aluResult`  output  WIDTH: combinational result.
- `zeroFlag`  output  1: combinational; 1 exactly when `aluResult == 0`.
- `overflow`  output  1: combinational; signed overflow of the current ADD/SUB, else 0.
- `carryOut`  output  1: combinational; carry out of the adder for ADD (borrow-inverted for SUB), else 0.
- `ovfSticky`  output  1: registered; set on any clock edge where `overflow` is 1.

## Operation
- `aluControl` encoding:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B.
  - 011 reserved: result 0.
  - 100 ANDN: A & ~B.
  - 101 ORN: A | ~B.
  - 110 SUB: A - B.
  - 111 SLT: signed A < B gives 1, else 0, zero-extended to 32 bits.
- A single adder computes A + (B ^ {32{ctl[2]}}) + ctl[2]. SUB and SLT share it.
- Arithmetic wraps modulo 2^32. There are no traps; overflow is only reported.
- `overflow` rule: (A[31] == B'[31]) && (sum[31] != A[31]), where B' is the post-inversion operand. It is valid only for codes 010 and 110 and forced to 0 for every other code.
- SLT is computed as sum[31] XOR overflow-condition. This must be correct across the sign boundary. Example: A = 0x7FFFFFFF, B = 0x80000000 gives 0.
- `zeroFlag` is derived from the final `aluResult`, so the reserved code always gives `zeroFlag` = 1.
- Any undefined or X `aluControl` value gives result 0. No latches.

## Timing
- `aluResult`, `zeroFlag`, `overflow` and `carryOut` are purely combinational.
  - Zero latency from any input.
  - Independent of `clk` and `rst_n`.
- `ovfSticky`:
  - Reset value 0, cleared asynchronously while `rst_n` = 0.
  - On posedge `clk` with `rst_n` = 1, set when `overflow` = 1; it holds once set.
  - It is cleared only by reset.
  - If reset is asserted mid-operation, `ovfSticky` goes to 0 immediately; the combinational outputs are unaffected.
  - If reset deassertion coincides with an overflowing input, the first sampling edge after deassertion sets it.
- The combinational path is a 32-bit add plus a 32-input zero-detect. It must close timing within one `EX` cycle.

## Structure
- `alu_pkg` holds:
  - the `alu_op_e` enum for the eight `aluControl` codes, including `ALU_RSVD` = 3'b011;
  - the `ALU_WIDTH` = 32 constant.
- One sub-module `alu_addsub` contains the shared add/subtract adder.
  - Inputs: A, B, sub.
  - Outputs: sum, carry, overflow.
- Result mux, zero-detect and the sticky register stay in `alu`.

## Test plan
- Logic ops: A = 0xF0F0F0F0, B = 0x0FF00FF0 must give:
  - AND = 0x00F000F0;
  - OR = 0xFFF0FFF0;
  - ANDN = 0xF000F000;
  - ORN = 0xF0FFF0FF;
  - `zeroFlag` = 0 for all four.
- ADD/SUB:
  - 7 + 5 = 12.
  - 5 - 5 = 0 with `zeroFlag` = 1.
  - 3 - 5 = 0xFFFFFFFE.
  - 0xFFFFFFFF + 1 = 0 with `carryOut` = 1 and `overflow` = 0.
- Overflow:
  - ADD 0x7FFFFFFF + 1 gives 0x80000000 with `overflow` = 1.
  - `ovfSticky` = 1 after the next `clk` edge, and stays 1 after the inputs return to 3 + 4.
  - Pulsing `rst_n` low clears it to 0 asynchronously.
- SLT:
  - (-1, 1) gives 1.
  - (1, -1) gives 0.
  - (5, 5) gives 0 with `zeroFlag` = 1.
  - (0x80000000, 0x7FFFFFFF) gives 1.
  - (0x7FFFFFFF, 0x80000000) gives 0.
- Reserved code: `aluControl` = 011 with A = 9, B = 4 gives `aluResult` = 0, `zeroFlag` = 1, `overflow` = 0.
- Reset: with `rst_n` held low and an ADD 2 + 3 applied, `aluResult` = 5, `zeroFlag` = 0 and `ovfSticky` = 0.
